// File: rtl/punch_judge.sv
// punch_judge: debounces the punch button, judges hits/misses against the LED sweep, keeps score.
// Build option PUNCH_JUDGE_PASS_MISS_EN: an unpunched pass of the target LED also counts as a miss.
module punch_judge #(
  parameter int unsigned TARGET_IDX     = 2,
  parameter int unsigned DEBOUNCE_CYC   = 16,
  parameter int unsigned COOLDOWN_STEPS = 2,
  parameter int unsigned MAX_MISSES     = 3,
  parameter int unsigned HITS_PER_LVL   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Led,
  input  logic       led_step,
  input  logic       btn,
  input  logic       start,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic [2:0] misses,
  output logic [2:0] level,
  output logic       game_over
);

  // state      | meaning
  // S_IDLE     | after reset, waiting for start; punches ignored
  // S_ARMED    | next punch is judged against Led
  // S_COOLDOWN | punches discarded until COOLDOWN_STEPS led_step pulses pass
  // S_OVER     | too many misses; score/misses frozen until start
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COOLDOWN, S_OVER} state_e;

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned CW = $clog2(COOLDOWN_STEPS + 1);
  localparam logic [4:0] TARGET_OH = 5'(1 << TARGET_IDX);

  logic          btn_s1_q, btn_s2_q, deb_q, punch_q;
  logic [DW-1:0] deb_cnt_q;

  state_e        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [2:0]    misses_q, misses_d, misses_inc;
  logic [CW-1:0] cool_q, cool_d;
  logic          hit_q, hit_d, miss_q, miss_d;
  logic          is_target;
  logic [7:0]    lvl_raw;

  // The counter reloads while the synchronised level matches the accepted one,
  // so any bounce restarts the full DEBOUNCE_CYC window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      punch_q   <= 1'b0;
    end else begin
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      punch_q  <= 1'b0;
      if (btn_s2_q == deb_q) begin
        deb_cnt_q <= DW'(DEBOUNCE_CYC - 1);
      end else if (deb_cnt_q == '0) begin
        deb_q     <= btn_s2_q;
        deb_cnt_q <= DW'(DEBOUNCE_CYC - 1);
        punch_q   <= btn_s2_q;
      end else begin
        deb_cnt_q <= deb_cnt_q - DW'(1);
      end
    end
  end

  assign is_target  = (Led == TARGET_OH);
  assign misses_inc = misses_q + 3'd1;

`ifdef PUNCH_JUDGE_PASS_MISS_EN
  logic dwell_punched_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_punched_q <= 1'b0;
    end else if (led_step) begin
      dwell_punched_q <= 1'b0;
    end else if (state_q == S_ARMED && punch_q && !start) begin
      dwell_punched_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    misses_d = misses_q;
    cool_d   = cool_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    if (start) begin
      state_d  = S_ARMED;
      score_d  = '0;
      misses_d = '0;
      cool_d   = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (punch_q) begin
            state_d = S_COOLDOWN;
            cool_d  = CW'(COOLDOWN_STEPS);
            if (is_target) begin
              hit_d = 1'b1;
              if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end else begin
              miss_d   = 1'b1;
              misses_d = misses_inc;
              if (misses_inc == 3'(MAX_MISSES)) state_d = S_OVER;
            end
          end
`ifdef PUNCH_JUDGE_PASS_MISS_EN
          else if (led_step && is_target && !dwell_punched_q) begin
            miss_d   = 1'b1;
            misses_d = misses_inc;
            if (misses_inc == 3'(MAX_MISSES)) state_d = S_OVER;
          end
`endif
        end
        S_COOLDOWN: begin
          if (led_step) begin
            if (cool_q == CW'(1)) begin
              state_d = S_ARMED;
              cool_d  = '0;
            end else begin
              cool_d = cool_q - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      misses_q <= '0;
      cool_q   <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      cool_q   <= cool_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign lvl_raw   = score_q / 8'(HITS_PER_LVL);
  assign level     = (lvl_raw > 8'd7) ? 3'd7 : lvl_raw[2:0];
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_punch_judge.sv
// tb_punch_judge: randomized punches over a modelled LED sweep; a game-rule model feeds a
// scoreboard queue that a negedge monitor drains whenever hit or miss pulses.
`timescale 1ns/1ps
module tb_punch_judge;
  localparam int TARGET = 2;
  localparam int DEB    = 16;
  localparam int COOL   = 2;
  localparam int MAXM   = 3;
  localparam int HPL    = 4;
  localparam int LAT    = DEB + 2;
  localparam logic [4:0] TARGET_OH = 5'(1 << TARGET);

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [4:0] Led = '0;
  logic       led_step = 1'b0, btn = 1'b0, start = 1'b0;
  logic       hit, miss, game_over;
  logic [7:0] score;
  logic [2:0] misses, level;

  punch_judge #(
    .TARGET_IDX(TARGET), .DEBOUNCE_CYC(DEB), .COOLDOWN_STEPS(COOL),
    .MAX_MISSES(MAXM), .HITS_PER_LVL(HPL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Led(Led), .led_step(led_step), .btn(btn), .start(start),
    .hit(hit), .miss(miss), .score(score), .misses(misses), .level(level), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit is_hit; int score; int misses; bit over;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   pq[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   mon_en = 0;

  int   step_period = 6, step_cnt = 0, pos = 0, dir = 1, dwell_start = 0;
  bit   fixed_en = 0, glitch_en = 0, rand_start = 0, prev_step = 0;
  logic [4:0] fixed_led = '0;

  bit m_active, m_over;
  int m_score, m_misses, m_cool, m_last_punch;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int exp_level(int s);
    return (s / HPL > 7) ? 7 : s / HPL;
  endfunction

  function automatic void model_reset();
    m_active = 0; m_over = 0; m_score = 0; m_misses = 0; m_cool = 0; m_last_punch = -1000;
  endfunction

  function automatic void push_exp(bit is_hit);
    exp_t e;
    e.cyc = cyc + 1; e.is_hit = is_hit; e.score = m_score; e.misses = m_misses; e.over = m_over;
    exp_q.push_back(e);
  endfunction

  task automatic drive_led();
    if (prev_step) dwell_start = cyc;
    led_step = (step_cnt == 0);
    if (fixed_en) Led = fixed_led;
    else if (glitch_en && $urandom_range(0, 7) == 0) Led = 5'($urandom_range(0, 31));
    else Led = 5'(1 << pos);
    if (led_step && !fixed_en) begin
      if (pos == 4) dir = -1;
      else if (pos == 0) dir = 1;
      pos += dir;
    end
    step_cnt  = (step_cnt == 0) ? step_period - 1 : step_cnt - 1;
    prev_step = led_step;
  endtask

  // Game rules for the current cycle's inputs: start wins, cooldown counts led_steps,
  // otherwise a punch is judged against the Led value visible in that cycle.
  task automatic model_eval();
    bit punch = 0;
    while (pq.size() > 0 && pq[0] < cyc) void'(pq.pop_front());
    if (pq.size() > 0 && pq[0] == cyc) begin punch = 1; void'(pq.pop_front()); end
    if (start) begin
      m_active = 1; m_over = 0; m_score = 0; m_misses = 0; m_cool = 0;
    end else if (m_active && !m_over) begin
      if (m_cool > 0) begin
        if (led_step) m_cool--;
      end else if (punch) begin
        m_last_punch = cyc;
        if (Led == TARGET_OH) m_score = (m_score == 255) ? 255 : m_score + 1;
        else m_misses++;
        if (m_misses >= MAXM) m_over = 1; else m_cool = COOL;
        push_exp(Led == TARGET_OH);
      end
`ifdef PUNCH_JUDGE_PASS_MISS_EN
      else if (led_step && Led == TARGET_OH && m_last_punch < dwell_start) begin
        m_misses++;
        if (m_misses >= MAXM) m_over = 1;
        push_exp(1'b0);
      end
`endif
    end
  endtask

  task automatic tick();
    drive_led();
    model_eval();
    @(posedge clk); #1;
    cyc++;
    start = 0;
  endtask

  task automatic press(int hold, int rel);
    btn = 1;
    pq.push_back(cyc + LAT);
    repeat (hold) tick();
    btn = 0;
    repeat (rel) begin
      if (rand_start && $urandom_range(0, 49) == 0) start = 1;
      tick();
    end
  endtask

  task automatic check_state(string name);
    chk({name, ".score"}, int'(score), m_score);
    chk({name, ".misses"}, int'(misses), m_misses);
    chk({name, ".game_over"}, int'(game_over), int'(m_over));
    chk({name, ".level"}, int'(level), exp_level(m_score));
  endtask

  task automatic drain(string name, int n);
    repeat (n) tick();
    chk({name, ".pending_pulses"}, exp_q.size(), 0);
    exp_q.delete();
    check_state(name);
  endtask

  always @(negedge clk) begin
    if (mon_en && (hit || miss)) begin
      if (hit && miss) chk("hit_miss_exclusive", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("pulse_is_hit", int'(hit), int'(mon_e.is_hit));
        chk("pulse_score", int'(score), mon_e.score);
        chk("pulse_misses", int'(misses), mon_e.misses);
        chk("pulse_level", int'(level), exp_level(mon_e.score));
        chk("pulse_game_over", int'(game_over), int'(mon_e.over));
      end
    end
  end

  initial begin
    int p;
    model_reset();
    #2;
    chk("rst.hit", int'(hit), 0);
    chk("rst.miss", int'(miss), 0);
    check_state("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1;
    mon_en = 1;

    // directed hit on the target LED
    fixed_en = 1; fixed_led = TARGET_OH; step_period = 4;
    start = 1; tick();
    press(24, 30);
    drain("t1", 5);
    chk("t1.score_one", int'(score), 1);

    // wrong LED, then a second punch inside a long cooldown
    fixed_led = 5'b00001; step_period = 40;
    press(24, 24);
    press(24, 24);
    drain("t2", 100);
    chk("t2.misses_one", int'(misses), 1);

    // misses until game over, punches ignored, then restart
    step_period = 4;
    press(24, 24);
    press(24, 24);
    chk("t3.game_over", int'(game_over), 1);
    press(24, 24);
    press(24, 24);
    drain("t3_over", 5);
    start = 1; tick();
    check_state("t3_restart");
    chk("t3.game_over_clear", int'(game_over), 0);

    // bouncing button, then a clean hold: a single punch
    fixed_led = TARGET_OH;
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      repeat (5) tick();
    end
    btn = 1;
    pq.push_back(cyc + LAT);
    repeat (30) tick();
    btn = 0;
    repeat (24) tick();
    drain("t4", 5);
    chk("t4.one_hit", int'(score), 1);

    // reset asserted just as a hit pulse would appear
    btn = 1;
    p = cyc + LAT;
    pq.push_back(p);
    while (cyc <= p) tick();
    btn = 0; rst_n = 0;
    exp_q.delete(); pq.delete(); model_reset();
    #2;
    chk("mid_rst.hit", int'(hit), 0);
    check_state("mid_rst");
    repeat (3) tick();
    rst_n = 1;
    repeat (3) tick();

    // randomized play over a bouncing sweep with glitched Led values
    fixed_en = 0; glitch_en = 1; rand_start = 1;
    start = 1; tick();
    for (int i = 0; i < 60; i++) begin
      step_period = $urandom_range(3, 12);
      if ((!m_active || m_over) && $urandom_range(0, 1) == 1) start = 1;
      tick();
      press($urandom_range(22, 40), $urandom_range(22, 60));
    end
    glitch_en = 0; rand_start = 0;
    drain("rand", 80);

    // sweep runs with no punches
    step_period = 5;
    start = 1; tick();
    repeat (200) tick();
    drain("pass", 5);
`ifdef PUNCH_JUDGE_PASS_MISS_EN
    chk("pass.game_over", int'(game_over), 1);
`else
    chk("pass.misses_zero", int'(misses), 0);
`endif

    // score saturation
    fixed_en = 1; fixed_led = TARGET_OH; step_period = 4;
    start = 1; tick();
    repeat (256) press(22, 22);
    drain("sat", 5);
    chk("sat.score", int'(score), 255);
    chk("sat.level", int'(level), 7);

    // start and punch in the same cycle
    btn = 1;
    p = cyc + LAT;
    pq.push_back(p);
    while (cyc < p) tick();
    start = 1; tick();
    repeat (6) tick();
    btn = 0;
    repeat (24) tick();
    drain("start_punch", 5);
    chk("start_punch.score", int'(score), 0);
    press(24, 24);
    drain("after_restart", 5);
    chk("after_restart.score", int'(score), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
